// File: rtl/rgb_stream_packer_pkg.sv
`default_nettype none
// ============================================================================
// rgb_stream_packer_pkg : shared byte/pixel types for the RGB stream packer
// Rev 1.0 - initial release
// ============================================================================
package rgb_stream_packer_pkg;

  typedef logic [7:0]      byte_t;
  typedef logic [1:0]      count_t;
  typedef logic [2:0][7:0] bytes3_t;
  typedef logic [3:0][7:0] bytes4_t;

  // Index 0 is the lowest-addressed stream byte, so blue lands in lane 0.
  function automatic bytes3_t pixel_bytes(input byte_t r, input byte_t g, input byte_t b);
    return {r, g, b};
  endfunction

endpackage
`default_nettype wire

// File: rtl/rgb_stream_packer_if.sv
`default_nettype none
// ============================================================================
// pixel_stream_if / axis32_if : pixel-generator and 32-bit AXI4-Stream bundles
// Rev 1.0 - initial release
// ============================================================================
interface pixel_stream_if;
  logic [7:0] r;
  logic [7:0] g;
  logic [7:0] b;
  logic       valid;
  logic       sof;
  logic       eol;
  logic       in_stream_ready;

  modport master (output r, g, b, valid, sof, eol, input in_stream_ready);
  modport slave  (input r, g, b, valid, sof, eol, output in_stream_ready);
endinterface

interface axis32_if;
  logic [31:0] out_stream_tdata;
  logic [3:0]  out_stream_tkeep;
  logic        out_stream_tlast;
  logic        out_stream_tuser;
  logic        out_stream_tvalid;
  logic        out_stream_tready;

  modport master (output out_stream_tdata, out_stream_tkeep, out_stream_tlast,
                  output out_stream_tuser, out_stream_tvalid, input out_stream_tready);
  modport slave  (input out_stream_tdata, out_stream_tkeep, out_stream_tlast,
                  input out_stream_tuser, out_stream_tvalid, output out_stream_tready);
endinterface
`default_nettype wire

// File: rtl/rgb_stream_packer.sv
`default_nettype none
// ============================================================================
// rgb_stream_packer : packs 24-bit RGB pixels into a 32-bit AXI4-Stream
// Rev 1.0 - initial release
// ============================================================================
module rgb_stream_packer
  import rgb_stream_packer_pkg::*;
(
  input  logic          aclk,
  input  logic          aresetn,
  pixel_stream_if.slave pix,
  axis32_if.master      axis
);

  localparam logic [3:0] KEEP_ALL = 4'hF;

  bytes3_t     lo_q, lo_d;
  count_t      n_q, n_d;
  logic        flush_q, flush_d;
  logic        sof_pend_q, sof_pend_d;
  logic [31:0] tdata_q, tdata_d;
  logic        tlast_q, tlast_d;
  logic        tuser_q, tuser_d;
  logic        tvalid_q, tvalid_d;

  logic    slot_free;
  logic    ready;
  logic    accept;
  count_t  n_eff;
  bytes3_t px;
  bytes3_t rem;
  bytes4_t pack_word;
  bytes4_t flush_word;

  assign slot_free = !tvalid_q || axis.out_stream_tready;
  assign ready     = aresetn && slot_free && !flush_q;
  assign accept    = pix.valid && ready;
  assign px        = pixel_bytes(pix.r, pix.g, pix.b);
  // An sof pixel resyncs the stream: any leftover bytes are abandoned.
  assign n_eff     = pix.sof ? 2'd0 : n_q;

  always_comb begin : lane_mux
    pack_word  = '0;
    rem        = '0;
    flush_word = '0;
    case (n_eff)
      2'd1: pack_word = {px[2], px[1], px[0], lo_q[0]};
      2'd2: begin
        pack_word = {px[1], px[0], lo_q[1], lo_q[0]};
        rem[0]    = px[2];
      end
      2'd3: begin
        pack_word = {px[0], lo_q[2], lo_q[1], lo_q[0]};
        rem[0]    = px[1];
        rem[1]    = px[2];
      end
      default: rem = px;
    endcase
    for (int k = 0; k < 3; k++) begin
      if (k < int'(n_q)) flush_word[k] = lo_q[k];
    end
  end

  always_comb begin : next_state
    lo_d       = lo_q;
    n_d        = n_q;
    flush_d    = flush_q;
    sof_pend_d = sof_pend_q;
    tdata_d    = tdata_q;
    tlast_d    = tlast_q;
    tuser_d    = tuser_q;
    tvalid_d   = tvalid_q;

    if (tvalid_q && axis.out_stream_tready) tvalid_d = 1'b0;

    if (flush_q && slot_free) begin
      tdata_d    = flush_word;
      tlast_d    = 1'b1;
      tuser_d    = sof_pend_q;
      tvalid_d   = 1'b1;
      sof_pend_d = 1'b0;
      flush_d    = 1'b0;
      n_d        = 2'd0;
    end else if (accept) begin
      if (n_eff == 2'd0) begin
        lo_d       = px;
        n_d        = 2'd3;
        sof_pend_d = pix.sof ? 1'b1 : sof_pend_q;
        flush_d    = pix.eol;
      end else begin
        tdata_d    = pack_word;
        tuser_d    = sof_pend_q;
        tvalid_d   = 1'b1;
        sof_pend_d = 1'b0;
        lo_d       = rem;
        n_d        = count_t'(n_eff - 2'd1);
        // eol with nothing left over ends the line on this word; otherwise a flush word follows.
        tlast_d    = pix.eol && (n_eff == 2'd1);
        flush_d    = pix.eol && (n_eff != 2'd1);
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      lo_q       <= '0;
      n_q        <= '0;
      flush_q    <= 1'b0;
      sof_pend_q <= 1'b0;
      tdata_q    <= '0;
      tlast_q    <= 1'b0;
      tuser_q    <= 1'b0;
      tvalid_q   <= 1'b0;
    end else begin
      lo_q       <= lo_d;
      n_q        <= n_d;
      flush_q    <= flush_d;
      sof_pend_q <= sof_pend_d;
      tdata_q    <= tdata_d;
      tlast_q    <= tlast_d;
      tuser_q    <= tuser_d;
      tvalid_q   <= tvalid_d;
    end
  end

  assign pix.in_stream_ready    = ready;
  assign axis.out_stream_tdata  = tdata_q;
  assign axis.out_stream_tkeep  = KEEP_ALL;
  assign axis.out_stream_tlast  = tlast_q;
  assign axis.out_stream_tuser  = tuser_q;
  assign axis.out_stream_tvalid = tvalid_q;

endmodule
`default_nettype wire

// File: tb/tb_rgb_stream_packer.sv
`default_nettype none
// ============================================================================
// tb_rgb_stream_packer : randomized bench with a byte-queue reference model
// Rev 1.0 - initial release
// ============================================================================
module tb_rgb_stream_packer;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  pixel_stream_if pix();
  axis32_if       axis();

  rgb_stream_packer dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .pix     (pix.slave),
    .axis    (axis.master)
  );

  typedef struct packed {
    logic        user;
    logic        last;
    logic [31:0] data;
  } word_t;

  int n_checks    = 0;
  int n_fail      = 0;
  int ready_waits = 0;
  int tready_mode = 0;

  logic [7:0] byte_q[$];
  logic       user_q[$];
  logic       last_q[$];
  word_t      exp_q[$];
  word_t      obs_q[$];

  logic [7:0] pr[4];
  logic [7:0] pg[4];
  logic [7:0] pb[4];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: the stream is a byte queue; every 4 bytes form a word, eol flushes the rest.
  function automatic void emit_word(input int cnt);
    word_t w;
    w = '0;
    for (int i = 0; i < cnt; i++) begin
      w.data[8*i +: 8] = byte_q.pop_front();
      w.user = w.user | user_q.pop_front();
      w.last = w.last | last_q.pop_front();
    end
    exp_q.push_back(w);
  endfunction

  function automatic void model_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                                      input logic sof, input logic eol);
    if (sof) begin
      byte_q.delete();
      user_q.delete();
      last_q.delete();
    end
    byte_q.push_back(b); user_q.push_back(sof);  last_q.push_back(1'b0);
    byte_q.push_back(g); user_q.push_back(1'b0); last_q.push_back(1'b0);
    byte_q.push_back(r); user_q.push_back(1'b0); last_q.push_back(eol);
    while (byte_q.size() >= 4) emit_word(4);
    if (eol && byte_q.size() > 0) emit_word(byte_q.size());
  endfunction

  function automatic void model_reset();
    byte_q.delete();
    user_q.delete();
    last_q.delete();
    exp_q.delete();
  endfunction

  // Expected words of a 4-pixel group taken straight from the documented lane layout.
  function automatic logic [31:0] layout_word(input int w);
    case (w)
      0:       return {pb[1], pr[0], pg[0], pb[0]};
      1:       return {pg[2], pb[2], pr[1], pg[1]};
      default: return {pr[3], pg[3], pb[3], pr[2]};
    endcase
  endfunction

  always @(posedge aclk) begin
    #1;
    case (tready_mode)
      0:       axis.out_stream_tready = 1'b1;
      1:       axis.out_stream_tready = ($urandom_range(0, 2) != 0);
      default: axis.out_stream_tready = 1'b0;
    endcase
  end

  // Output monitor: scoreboard against the model plus hold-while-stalled checks.
  initial begin
    logic  stall_prev;
    word_t held;
    word_t cur_w;
    word_t exp_w;
    stall_prev = 1'b0;
    held       = '0;
    forever begin
      @(negedge aclk);
      cur_w = '{user: axis.out_stream_tuser, last: axis.out_stream_tlast,
                data: axis.out_stream_tdata};
      if (!aresetn) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check_eq("hold_valid", 64'(axis.out_stream_tvalid), 64'd1);
          check_eq("hold_word", 64'(cur_w), 64'(held));
        end
        if (axis.out_stream_tvalid && !axis.out_stream_tready)
          check_eq("stall_ready", 64'(pix.in_stream_ready), 64'd0);
        if (axis.out_stream_tvalid && axis.out_stream_tready) begin
          check_eq("tkeep", 64'(axis.out_stream_tkeep), 64'hF);
          check_eq("word_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            exp_w = exp_q.pop_front();
            check_eq("word", 64'(cur_w), 64'(exp_w));
          end
          obs_q.push_back(cur_w);
        end
        stall_prev = axis.out_stream_tvalid && !axis.out_stream_tready;
        held       = cur_w;
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the pixel.
  task automatic send_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                            input logic sof, input logic eol);
    bit done;
    done      = 1'b0;
    pix.r     = r;
    pix.g     = g;
    pix.b     = b;
    pix.sof   = sof;
    pix.eol   = eol;
    pix.valid = 1'b1;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge aclk);
      if (pix.in_stream_ready) begin
        model_pixel(r, g, b, sof, eol);
        done = 1'b1;
      end else begin
        ready_waits++;
      end
      @(posedge aclk);
      #1;
    end
    if (!done) check_eq("send_timeout", 64'(pix.in_stream_ready), 64'd1);
    pix.valid = 1'b0;
    pix.sof   = 1'b0;
    pix.eol   = 1'b0;
  endtask

  task automatic drain();
    bit idle;
    idle = 1'b0;
    for (int t = 0; t < 2000 && !idle; t++) begin
      @(negedge aclk);
      idle = (exp_q.size() == 0) && !axis.out_stream_tvalid;
    end
    check_eq("drain", 64'(exp_q.size()), 64'd0);
    @(posedge aclk);
    #1;
  endtask

  task automatic send_line(input int len);
    for (int i = 0; i < len; i++)
      send_pixel(8'($urandom), 8'($urandom), 8'($urandom), i == 0, i == len - 1);
  endtask

  task automatic check_line(input string tag, input int words);
    int lasts;
    int users;
    lasts = 0;
    users = 0;
    foreach (obs_q[i]) begin
      lasts += int'(obs_q[i].last);
      users += int'(obs_q[i].user);
    end
    check_eq({tag, "_words"}, 64'(obs_q.size()), 64'(words));
    check_eq({tag, "_tlast_count"}, 64'(lasts), 64'd1);
    check_eq({tag, "_tuser_count"}, 64'(users), 64'd1);
    if (obs_q.size() == words) begin
      check_eq({tag, "_tlast_final"}, 64'(obs_q[words-1].last), 64'd1);
      check_eq({tag, "_tuser_first"}, 64'(obs_q[0].user), 64'd1);
    end
  endtask

  initial begin
    pix.r = '0; pix.g = '0; pix.b = '0;
    pix.valid = 1'b0; pix.sof = 1'b0; pix.eol = 1'b0;
    axis.out_stream_tready = 1'b1;

    // Reset state
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check_eq("rst_tvalid", 64'(axis.out_stream_tvalid), 64'd0);
    check_eq("rst_tlast",  64'(axis.out_stream_tlast),  64'd0);
    check_eq("rst_tuser",  64'(axis.out_stream_tuser),  64'd0);
    check_eq("rst_tdata",  64'(axis.out_stream_tdata),  64'd0);
    check_eq("rst_ready",  64'(pix.in_stream_ready),    64'd0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;

    // Fixed 4-pixel group
    obs_q.delete();
    for (int i = 0; i < 4; i++)
      send_pixel(8'(8'h01 + 16*i), 8'(8'h02 + 16*i), 8'(8'h03 + 16*i), 1'b0, 1'b0);
    drain();
    check_eq("grp_words", 64'(obs_q.size()), 64'd3);
    if (obs_q.size() == 3) begin
      check_eq("grp_w0", 64'(obs_q[0].data), 64'h13010203);
      check_eq("grp_w1", 64'(obs_q[1].data), 64'h22231112);
      check_eq("grp_w2", 64'(obs_q[2].data), 64'h31323321);
    end

    // sof on the first pixel, eol on the fourth
    obs_q.delete();
    for (int i = 0; i < 4; i++) begin
      pr[i] = 8'($urandom); pg[i] = 8'($urandom); pb[i] = 8'($urandom);
    end
    for (int i = 0; i < 4; i++) send_pixel(pr[i], pg[i], pb[i], i == 0, i == 3);
    drain();
    check_eq("sof_words", 64'(obs_q.size()), 64'd3);
    if (obs_q.size() == 3) begin
      for (int w = 0; w < 3; w++) begin
        check_eq("sof_layout", 64'(obs_q[w].data), 64'(layout_word(w)));
        check_eq("sof_tuser",  64'(obs_q[w].user), 64'(w == 0));
        check_eq("sof_tlast",  64'(obs_q[w].last), 64'(w == 2));
      end
    end

    // eol on a lone pixel forces a zero-padded flush word
    obs_q.delete();
    send_pixel(8'h01, 8'h02, 8'h03, 1'b0, 1'b1);
    @(negedge aclk);
    check_eq("flush_ready", 64'(pix.in_stream_ready), 64'd0);
    @(posedge aclk);
    #1;
    drain();
    check_eq("flush_words", 64'(obs_q.size()), 64'd1);
    if (obs_q.size() == 1)
      check_eq("flush_word", 64'(obs_q[0]), 64'({1'b0, 1'b1, 32'h00010203}));

    // 640-pixel line at full rate
    obs_q.delete();
    ready_waits = 0;
    send_line(640);
    check_eq("full_rate_waits", 64'(ready_waits), 64'd0);
    drain();
    check_line("line_fast", 480);

    // 640-pixel line with random back-pressure
    obs_q.delete();
    tready_mode = 1;
    send_line(640);
    drain();
    check_line("line_bp", 480);

    // Random pixels, flags, gaps and back-pressure
    for (int i = 0; i < 400; i++) begin
      send_pixel(8'($urandom), 8'($urandom), 8'($urandom),
                 $urandom_range(0, 15) == 0, $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge aclk);
          #1;
        end
      end
    end
    drain();

    // Reset with two leftover bytes, then a clean group
    tready_mode = 0;
    send_pixel(8'hA1, 8'hA2, 8'hA3, 1'b1, 1'b0);
    send_pixel(8'hB1, 8'hB2, 8'hB3, 1'b0, 1'b0);
    drain();
    aresetn = 1'b0;
    @(negedge aclk);
    check_eq("rst_mid_ready", 64'(pix.in_stream_ready), 64'd0);
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    model_reset();
    obs_q.delete();
    for (int i = 0; i < 4; i++) begin
      pr[i] = 8'($urandom); pg[i] = 8'($urandom); pb[i] = 8'($urandom);
    end
    for (int i = 0; i < 4; i++) send_pixel(pr[i], pg[i], pb[i], 1'b0, 1'b0);
    drain();
    check_eq("rst_clean_words", 64'(obs_q.size()), 64'd3);
    if (obs_q.size() == 3) begin
      check_eq("rst_clean_w0", 64'(obs_q[0].data), 64'(layout_word(0)));
      check_eq("rst_clean_w2", 64'(obs_q[2].data), 64'(layout_word(2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
